// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 9x oversampled, majority-voted bit recovery
// with optional parity and frame error reporting.
module uart_rx_ctrl #(
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       rxd,
   input  logic       sample_clk,
   output logic       rx_start,
   output logic       rx_done,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t     state_q;
   logic       rxd_s1_q;
   logic       rxd_s2_q;
   logic       rxd_prev_q;
   logic [1:0] sync_ok_q;
   logic [3:0] tick_q;
   logic [3:0] tick_d;
   logic [2:0] bit_q;
   logic [1:0] vote_q;
   logic       bit_v_q;
   logic [7:0] shift_q;
   logic       par_err_q;
   logic [7:0] rx_data_q;
   logic       frame_err_q;
   logic       parity_err_q;
   logic       rx_start_q;
   logic       rx_done_q;
   logic       rx_valid_q;
   logic       fall;
   logic       maj;
   logic       par_exp;

   // prev only holds 1 once s2 carries a real line sample, so a line
   // already low at reset release is not mistaken for a start edge
   assign fall    = rxd_prev_q & ~rxd_s2_q;
   assign maj     = (vote_q[0] & vote_q[1]) |
                    (vote_q[0] & rxd_s2_q) |
                    (vote_q[1] & rxd_s2_q);
   assign tick_d  = (tick_q == 4'd8) ? 4'd0 : tick_q + 4'd1;
   assign par_exp = (^shift_q) ^ PARITY_ODD;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q      <= IDLE;
         rxd_s1_q     <= 1'b1;
         rxd_s2_q     <= 1'b1;
         rxd_prev_q   <= 1'b0;
         sync_ok_q    <= 2'b00;
         tick_q       <= 4'd0;
         bit_q        <= 3'd0;
         vote_q       <= 2'b00;
         bit_v_q      <= 1'b0;
         shift_q      <= 8'h00;
         par_err_q    <= 1'b0;
         rx_data_q    <= 8'h00;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         rx_start_q   <= 1'b0;
         rx_done_q    <= 1'b0;
         rx_valid_q   <= 1'b0;
      end else begin
         rxd_s1_q   <= rxd;
         rxd_s2_q   <= rxd_s1_q;
         sync_ok_q  <= {sync_ok_q[0], 1'b1};
         rxd_prev_q <= rxd_s2_q & sync_ok_q[1];
         rx_start_q <= 1'b0;
         rx_done_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         if (state_q == IDLE) begin
            tick_q <= 4'd0;
            bit_q  <= 3'd0;
            if (fall) begin
               state_q    <= START;
               rx_start_q <= 1'b1;
            end
         end else if (sample_clk) begin
            tick_q <= tick_d;
            if (tick_q == 4'd3) vote_q[0] <= rxd_s2_q;
            if (tick_q == 4'd4) vote_q[1] <= rxd_s2_q;
            if (tick_q == 4'd5) bit_v_q   <= maj;
            unique case (state_q)
               START: if (tick_q == 4'd8) begin
                  if (bit_v_q) begin
                     state_q   <= IDLE;
                     rx_done_q <= 1'b1;
                  end else begin
                     state_q <= DATA;
                  end
               end
               DATA: if (tick_q == 4'd8) begin
                  shift_q <= {bit_v_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7)
                     state_q <= PARITY_EN ? PARITY : STOP;
               end
               PARITY: if (tick_q == 4'd8) begin
                  par_err_q <= bit_v_q ^ par_exp;
                  state_q   <= STOP;
               end
               STOP: if (tick_q == 4'd5) begin
                  rx_valid_q   <= 1'b1;
                  rx_done_q    <= 1'b1;
                  rx_data_q    <= shift_q;
                  frame_err_q  <= ~maj;
                  parity_err_q <= PARITY_EN ? par_err_q : 1'b0;
                  state_q      <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_start   = rx_start_q;
   assign rx_done    = rx_done_q;
   assign rx_valid   = rx_valid_q;
   assign rx_data    = rx_data_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: one receiver without parity and one
// with even parity share the same serial line and sample tick.
module tb_uart_rx_ctrl;

   logic       clk;
   logic       reset_p;
   logic       rxd;
   logic       sample_clk;
   logic       rx_start0, rx_done0, rx_valid0;
   logic       frame_err0, parity_err0, busy0;
   logic [7:0] rx_data0;
   logic       rx_start1, rx_done1, rx_valid1;
   logic       frame_err1, parity_err1, busy1;
   logic [7:0] rx_data1;

   int vectors = 0;
   int miscompares = 0;
   int st0 = 0, dn0 = 0, vl0 = 0, both0 = 0;
   int st1 = 0, dn1 = 0, vl1 = 0, both1 = 0;
   logic v0_at, v1_at;

   uart_rx_ctrl dut0 (
      .clk(clk), .reset_p(reset_p), .rxd(rxd), .sample_clk(sample_clk),
      .rx_start(rx_start0), .rx_done(rx_done0), .rx_data(rx_data0),
      .rx_valid(rx_valid0), .frame_err(frame_err0),
      .parity_err(parity_err0), .busy(busy0)
   );

   uart_rx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
      .clk(clk), .reset_p(reset_p), .rxd(rxd), .sample_clk(sample_clk),
      .rx_start(rx_start1), .rx_done(rx_done1), .rx_data(rx_data1),
      .rx_valid(rx_valid1), .frame_err(frame_err1),
      .parity_err(parity_err1), .busy(busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one-cycle tick every 12 clocks, changed on the falling edge
   initial begin
      sample_clk = 1'b0;
      forever begin
         repeat (11) @(negedge clk);
         sample_clk = 1'b1;
         @(negedge clk);
         sample_clk = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rx_start0) st0++;
      if (rx_done0) dn0++;
      if (rx_valid0) vl0++;
      if (rx_start0 && rx_done0) both0++;
      if (rx_start1) st1++;
      if (rx_done1) dn1++;
      if (rx_valid1) vl1++;
      if (rx_start1 && rx_done1) both1++;
   end

   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         while (sample_clk !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par,
                             input logic pbit, input logic sbit,
                             input int gl);
      rxd = 1'b1;
      wait_ticks(12);
      rxd = 1'b0;
      wait_ticks(9);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         if (i == gl) begin
            wait_ticks(4);
            rxd = ~b[i];
            wait_ticks(1);
            rxd = b[i];
            wait_ticks(4);
         end else begin
            wait_ticks(9);
         end
      end
      if (par) begin
         rxd = pbit;
         wait_ticks(9);
      end
      rxd = sbit;
      wait_ticks(6);
      @(negedge clk);
      v0_at = rx_valid0;
      v1_at = rx_valid1;
      wait_ticks(3);
      rxd = 1'b1;
   endtask

   task automatic test_reset;
      reset_p = 1'b1;
      rxd     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({rx_start0, rx_done0, rx_valid0, frame_err0,
           parity_err0, busy0} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {rx_start0, rx_done0, rx_valid0, frame_err0,
                   parity_err0, busy0});
      end
      vectors++;
      if (rx_data0 !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 00", rx_data0);
      end
      vectors++;
      if (busy1 !== 1'b0 || rx_data1 !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_dut1: got busy=%b data=%h expected 0/00",
                  busy1, rx_data1);
      end
      reset_p = 1'b0;
      wait_ticks(3);
      vectors++;
      if (busy0 !== 1'b0 || st0 !== 0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got busy=%b starts=%0d expected 0/0",
                  busy0, st0);
      end
   endtask

   task automatic test_nominal;
      int s, d, v;
      s = st0; d = dn0; v = vl0;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
      vectors++;
      if (v0_at !== 1'b1) begin
         miscompares++;
         $display("FAIL nominal_latency: got valid=%b expected 1", v0_at);
      end
      vectors++;
      if (rx_data0 !== 8'h5A) begin
         miscompares++;
         $display("FAIL nominal_data: got %h expected 5a", rx_data0);
      end
      vectors++;
      if (frame_err0 !== 1'b0 || parity_err0 !== 1'b0) begin
         miscompares++;
         $display("FAIL nominal_errs: got fe=%b pe=%b expected 0/0",
                  frame_err0, parity_err0);
      end
      vectors++;
      if (st0 - s !== 1 || dn0 - d !== 1 || vl0 - v !== 1) begin
         miscompares++;
         $display("FAIL nominal_pulses: got start=%0d done=%0d valid=%0d expected 1/1/1",
                  st0 - s, dn0 - d, vl0 - v);
      end
   endtask

   task automatic test_glitch;
      int s, d, v;
      s = st0; d = dn0; v = vl0;
      rxd = 1'b1;
      wait_ticks(12);
      rxd = 1'b0;
      wait_ticks(2);
      rxd = 1'b1;
      wait_ticks(12);
      vectors++;
      if (st0 - s !== 1 || dn0 - d !== 1 || vl0 - v !== 0) begin
         miscompares++;
         $display("FAIL glitch_pulses: got start=%0d done=%0d valid=%0d expected 1/1/0",
                  st0 - s, dn0 - d, vl0 - v);
      end
      vectors++;
      if (rx_data0 !== 8'h5A || busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_hold: got data=%h busy=%b expected 5a/0",
                  rx_data0, busy0);
      end
   endtask

   task automatic test_majority;
      int v;
      v = vl0;
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 3);
      vectors++;
      if (rx_data0 !== 8'hFF || vl0 - v !== 1) begin
         miscompares++;
         $display("FAIL majority: got data=%h valid=%0d expected ff/1",
                  rx_data0, vl0 - v);
      end
   endtask

   task automatic test_parity;
      send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1);
      vectors++;
      if (v1_at !== 1'b1 || rx_data1 !== 8'h03) begin
         miscompares++;
         $display("FAIL parity_bad_frame: got valid=%b data=%h expected 1/03",
                  v1_at, rx_data1);
      end
      vectors++;
      if (parity_err1 !== 1'b1 || frame_err1 !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_bad_flag: got pe=%b fe=%b expected 1/0",
                  parity_err1, frame_err1);
      end
      send_frame(8'h03, 1'b1, 1'b0, 1'b1, -1);
      vectors++;
      if (v1_at !== 1'b1 || parity_err1 !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_good: got valid=%b pe=%b expected 1/0",
                  v1_at, parity_err1);
      end
      vectors++;
      if (parity_err0 !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_disabled: got pe=%b expected 0", parity_err0);
      end
   endtask

   task automatic test_break;
      int s, v;
      rxd = 1'b1;
      wait_ticks(12);
      s = st0; v = vl0;
      rxd = 1'b0;
      wait_ticks(180);
      vectors++;
      if (vl0 - v !== 1 || rx_data0 !== 8'h00 || frame_err0 !== 1'b1) begin
         miscompares++;
         $display("FAIL break_frame: got valid=%0d data=%h fe=%b expected 1/00/1",
                  vl0 - v, rx_data0, frame_err0);
      end
      vectors++;
      if (st0 - s !== 1 || busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL break_no_restart: got starts=%0d busy=%b expected 1/0",
                  st0 - s, busy0);
      end
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
      vectors++;
      if (st0 - s !== 2 || rx_data0 !== 8'h3C || frame_err0 !== 1'b0) begin
         miscompares++;
         $display("FAIL break_recover: got starts=%0d data=%h fe=%b expected 2/3c/0",
                  st0 - s, rx_data0, frame_err0);
      end
   endtask

   task automatic test_reset_mid_frame;
      int s, v;
      rxd = 1'b1;
      wait_ticks(12);
      rxd = 1'b0;
      wait_ticks(9);
      for (int i = 0; i < 4; i++) begin
         rxd = 1'b1;
         wait_ticks(9);
      end
      rxd = 1'b0;
      wait_ticks(4);
      reset_p = 1'b1;
      #2;
      vectors++;
      if ({rx_start0, rx_done0, rx_valid0, frame_err0, parity_err0,
           busy0} !== 6'b0 || rx_data0 !== 8'h00) begin
         miscompares++;
         $display("FAIL midreset_outputs: got flags=%b data=%h expected 000000/00",
                  {rx_start0, rx_done0, rx_valid0, frame_err0,
                   parity_err0, busy0}, rx_data0);
      end
      s = st0; v = vl0;
      repeat (3) @(posedge clk);
      #1;
      reset_p = 1'b0;
      wait_ticks(5 + 27);
      rxd = 1'b1;
      wait_ticks(9);
      vectors++;
      if (vl0 - v !== 0 || st0 - s !== 0 || busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_abort: got valid=%0d starts=%0d busy=%b expected 0/0/0",
                  vl0 - v, st0 - s, busy0);
      end
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      vectors++;
      if (v0_at !== 1'b1 || rx_data0 !== 8'hA5 || frame_err0 !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_next: got valid=%b data=%h fe=%b expected 1/a5/0",
                  v0_at, rx_data0, frame_err0);
      end
   endtask

   task automatic test_pulse_exclusive;
      vectors++;
      if (both0 !== 0 || both1 !== 0) begin
         miscompares++;
         $display("FAIL start_done_overlap: got %0d/%0d expected 0/0",
                  both0, both1);
      end
   endtask

   initial begin
      reset_p = 1'b1;
      rxd     = 1'b1;
      test_reset;
      test_nominal;
      test_glitch;
      test_majority;
      test_parity;
      test_break;
      test_reset_mid_frame;
      test_pulse_exclusive;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
